// File: rtl/eeg_epoch_loader_pkg.sv
// Shared definitions for the EEG epoch loader: epoch geometry, memory map, data types and FSM states.
package eeg_epoch_loader_pkg;

    localparam int NUM_PATCHES     = 30;
    localparam int PATCH_LEN       = 128;
    localparam int NUM_SAMPLES_DEF = NUM_PATCHES * PATCH_LEN;
    localparam int INT_RES_ADDR_W  = 16;
    localparam int COMP_FX_W       = 22;
    localparam int EEG_INPUT_MEM   = 0;

    typedef logic [INT_RES_ADDR_W-1:0]    IntResAddr_t;
    typedef logic signed [COMP_FX_W-1:0]  CompFx_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        PULSE    = 2'd2,
        WAIT_INF = 2'd3
    } LoaderState_t;

endpackage

// File: rtl/eeg_epoch_loader_if.sv
// Sample stream plus intermediate-result write port of the EEG epoch loader.
interface eeg_epoch_loader_if #(
    parameter int SAMPLE_W = 16,
    parameter int DATA_W   = 22,
    parameter int ADDR_W   = 16
) ();
    logic                       s_valid;
    logic                       s_ready;
    logic signed [SAMPLE_W-1:0] s_data;
    logic                       s_last;
    logic                       wr_stall;
    logic                       wr_en;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]          wr_data;

    modport slave (
        input  s_valid, s_data, s_last, wr_stall,
        output s_ready, wr_en, wr_addr, wr_data
    );

    modport master (
        output s_valid, s_data, s_last, wr_stall,
        input  s_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/eeg_epoch_loader_counter.sv
// Sample-index counter: synchronous clear has priority over increment.
module eeg_epoch_loader_counter #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt_o
);
    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/eeg_epoch_loader.sv
// Streams raw EEG samples into the intermediate-result memory as fixed point and flags each full epoch.
// Optional s_last framing check enabled by defining EEG_LAST_CHECK_EN.
module eeg_epoch_loader
    import eeg_epoch_loader_pkg::*;
#(
    parameter int NUM_SAMPLES = NUM_SAMPLES_DEF,
    parameter int SAMPLE_W    = 16,
    parameter int DATA_W      = COMP_FX_W,
    parameter int FRAC_BITS   = 6,
    parameter int ADDR_W      = INT_RES_ADDR_W,
    parameter int BASE_ADDR   = EEG_INPUT_MEM
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    eeg_epoch_loader_if.slave     bus,
    output logic                  new_sleep_epoch,
    input  logic                  inference_complete,
    output logic                  busy,
    output logic                  err
);
    localparam int CNT_W = $clog2(NUM_SAMPLES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

    if (SAMPLE_W + FRAC_BITS > DATA_W) begin : g_width_chk
        $fatal(1, "eeg_epoch_loader: SAMPLE_W+FRAC_BITS exceeds DATA_W, conversion would not be exact");
    end

    LoaderState_t               state_q, state_d;
    logic [CNT_W-1:0]           cnt;
    logic                       cnt_inc, cnt_clr;
    logic                       hs, cnt_is_last, frame_err;
    logic                       wr_en_q;
    logic [ADDR_W-1:0]          wr_addr_q;
    logic [DATA_W-1:0]          wr_data_q;
    logic                       pulse_q;
    logic signed [DATA_W-1:0]   sample_ext;

    eeg_epoch_loader_counter #(.WIDTH(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .cnt_o (cnt)
    );

    assign bus.s_ready = (state_q == LOAD) && !bus.wr_stall;
    assign hs          = (state_q == LOAD) && bus.s_valid && !bus.wr_stall;
    assign cnt_is_last = (cnt == LAST_IDX);
    assign sample_ext  = DATA_W'(bus.s_data);

`ifdef EEG_LAST_CHECK_EN
    logic err_q;
    assign frame_err = hs && (bus.s_last != cnt_is_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (frame_err) begin
            err_q <= 1'b1;
        end
    end
    assign err = err_q;
`else
    assign frame_err = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A framing error still writes its sample but abandons the epoch without a pulse.
    always_comb begin
        state_d = state_q;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm) state_d = LOAD;
            end
            LOAD: begin
                if (hs) begin
                    if (frame_err) begin
                        cnt_clr = 1'b1;
                        state_d = IDLE;
                    end else if (cnt_is_last) begin
                        cnt_clr = 1'b1;
                        state_d = PULSE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            PULSE:    state_d = WAIT_INF;
            WAIT_INF: begin
                if (inference_complete) state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase
    end

    // Pulse is registered off PULSE so it trails the final write by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            pulse_q   <= 1'b0;
        end else begin
            wr_en_q <= hs;
            pulse_q <= (state_q == PULSE);
            if (hs) begin
                wr_addr_q <= ADDR_W'(BASE_ADDR) + ADDR_W'(cnt);
                wr_data_q <= sample_ext <<< FRAC_BITS;
            end
        end
    end

    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign new_sleep_epoch = pulse_q;
    assign busy            = (state_q != IDLE);
endmodule
